div_32_bit: RTL and testbench

Sequential 32-bit integer divider for the datapath's DIV instruction. It takes a dividend `Q` and a divisor `M` and produces a 64-bit result `z`: the remainder in the upper half (HI) and the quotient in the lower half (LO). It uses the non-restoring shift/subtract algorithm, one quotient bit per clock, and a start/done handshake with the control unit.

---
 rtl/div_32_bit.sv | 191 +++++++++++++++++++
 tb/tb_div_32_bit.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/div_32_bit.sv
// div_32_bit : sequential 32-bit non-restoring divider for the DIV instruction.
// One quotient bit per clock; result z = {remainder, quotient}.
// Build option: define DIV_SIGNED_EN for two's-complement signed operands and
// results. Without it, operands and results are unsigned.
// Timing from the accepting edge (edge 0): iterations on edges 1-32, result
// and done on edge 33, back to idle on edge 34, next accept on edge 35.

module div_32_bit (
   input  logic        clk,
   input  logic        clr,
   input  logic        start,
   input  logic [31:0] M,
   input  logic [31:0] Q,
   output logic [63:0] z,
   output logic        busy,
   output logic        done,
   output logic        div_by_zero
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_FIX  = 2'd2,
      S_DONE = 2'd3
   } state_t;

   state_t      state_reg;
   state_t      state_next;

   // Iteration counter: counts the 32 RUN steps, wraps 31 -> 0.
   logic [4:0]  count_reg;

   // Partial remainder A carries an extra sign bit during the algorithm.
   logic [32:0] a_reg;
   logic [31:0] q_reg;        // dividend magnitude shifting into quotient
   logic [31:0] m_reg;        // divisor magnitude
   logic [31:0] q_raw_reg;    // dividend as presented, for divide-by-zero result
   logic        zero_reg;     // divisor was zero
   logic        q_neg_reg;    // quotient must be negated at the end
   logic        r_neg_reg;    // remainder must be negated at the end

   logic [63:0] z_reg;
   logic        busy_reg;
   logic        done_reg;
   logic        dbz_reg;

   // Operand preprocessing at acceptance.
   logic [31:0] q_mag;
   logic [31:0] m_mag;
   logic        q_neg_in;
   logic        r_neg_in;

`ifdef DIV_SIGNED_EN
   // Work on magnitudes; remember which result halves need their sign restored.
   // |-2^31| = 2^31 still fits in 32 unsigned bits.
   assign q_mag    = Q[31] ? (~Q + 32'd1) : Q;
   assign m_mag    = M[31] ? (~M + 32'd1) : M;
   assign q_neg_in = Q[31] ^ M[31];
   assign r_neg_in = Q[31];
`else
   assign q_mag    = Q;
   assign m_mag    = M;
   assign q_neg_in = 1'b0;
   assign r_neg_in = 1'b0;
`endif

   // One non-restoring step: shift {A,Q} left, then add or subtract M
   // depending on the sign of A before the shift.
   logic [32:0] shift_a;
   logic [32:0] m_ext;
   logic [32:0] a_step;
   logic [31:0] q_step;

   assign shift_a = {a_reg[31:0], q_reg[31]};
   assign m_ext   = {1'b0, m_reg};
   assign a_step  = a_reg[32] ? (shift_a + m_ext) : (shift_a - m_ext);
   assign q_step  = {q_reg[30:0], ~a_step[32]};

   // Final correction: a negative A is restored by adding M once. The
   // corrected remainder is non-negative and below M, so 32 bits suffice.
   logic [31:0] rem_mag;
   logic [31:0] rem_fix;
   logic [31:0] quot_fix;
   logic [63:0] z_next;

   assign rem_mag  = a_reg[32] ? (a_reg[31:0] + m_reg) : a_reg[31:0];
   assign rem_fix  = r_neg_reg ? (~rem_mag + 32'd1) : rem_mag;
   assign quot_fix = q_neg_reg ? (~q_reg + 32'd1) : q_reg;

   // Divide by zero returns the dividend in HI and all ones in LO.
   genvar gi;
   generate
      for (gi = 0; gi < 32; gi = gi + 1) begin : g_zmux
         assign z_next[gi]      = zero_reg ? 1'b1          : quot_fix[gi];
         assign z_next[gi + 32] = zero_reg ? q_raw_reg[gi] : rem_fix[gi];
      end
   endgenerate

   // State register.
   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         state_reg <= S_IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   // Next-state logic: IDLE -> RUN (32 steps) -> FIX -> DONE -> IDLE.
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         S_IDLE: begin
            if (start) begin
               state_next = S_RUN;
            end
         end
         S_RUN: begin
            if (count_reg == 5'd31) begin
               state_next = S_FIX;
            end
         end
         S_FIX: begin
            state_next = S_DONE;
         end
         S_DONE: begin
            state_next = S_IDLE;
         end
         default: begin
            state_next = S_IDLE;
         end
      endcase
   end

   // Datapath and handshake registers, updated according to the current state.
   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         count_reg <= 5'd0;
         a_reg     <= 33'd0;
         q_reg     <= 32'd0;
         m_reg     <= 32'd0;
         q_raw_reg <= 32'd0;
         zero_reg  <= 1'b0;
         q_neg_reg <= 1'b0;
         r_neg_reg <= 1'b0;
         z_reg     <= 64'd0;
         busy_reg  <= 1'b0;
         done_reg  <= 1'b0;
         dbz_reg   <= 1'b0;
      end else begin
         case (state_reg)
            S_IDLE: begin
               if (start) begin
                  count_reg <= 5'd0;
                  a_reg     <= 33'd0;
                  q_reg     <= q_mag;
                  m_reg     <= m_mag;
                  q_raw_reg <= Q;
                  zero_reg  <= (M == 32'd0);
                  q_neg_reg <= q_neg_in;
                  r_neg_reg <= r_neg_in;
                  busy_reg  <= 1'b1;
               end
            end
            S_RUN: begin
               a_reg     <= a_step;
               q_reg     <= q_step;
               count_reg <= count_reg + 5'd1;
            end
            S_FIX: begin
               z_reg    <= z_next;
               dbz_reg  <= zero_reg;
               done_reg <= 1'b1;
               busy_reg <= 1'b0;
            end
            S_DONE: begin
               done_reg <= 1'b0;
            end
            default: begin
               done_reg <= 1'b0;
               busy_reg <= 1'b0;
            end
         endcase
      end
   end

   assign z           = z_reg;
   assign busy        = busy_reg;
   assign done        = done_reg;
   assign div_by_zero = dbz_reg;

endmodule

// File: tb/tb_div_32_bit.sv
// tb_div_32_bit : scoreboard bench for div_32_bit. A driver issues divisions
// and pushes reference results; a monitor pops and compares on every done.
// Build with DIV_SIGNED_EN to match a signed DUT build.

module tb_div_32_bit;

   logic        clk;
   logic        clr;
   logic        start;
   logic [31:0] M;
   logic [31:0] Q;
   logic [63:0] z;
   logic        busy;
   logic        done;
   logic        div_by_zero;

   div_32_bit dut (
      .clk         (clk),
      .clr         (clr),
      .start       (start),
      .M           (M),
      .Q           (Q),
      .z           (z),
      .busy        (busy),
      .done        (done),
      .div_by_zero (div_by_zero)
   );

   typedef struct {
      logic [63:0] z;
      logic        dbz;
      int          acc;
   } exp_t;

   exp_t exp_q[$];
   int   total;
   int   bad;
   int   cyc;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Watchdog so the run always terminates.
   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached, required finish");
      $fatal(1);
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got 0x%0h required 0x%0h", name, act, req);
      end
   endtask

   // Reference model: plain arithmetic on the operands.
   function automatic exp_t model(input logic [31:0] qv, input logic [31:0] mv);
      exp_t   e;
      longint a;
      longint b;
      longint quo;
      longint rem;
      e.acc = 0;
      if (mv == 32'd0) begin
         e.z   = {qv, 32'hFFFF_FFFF};
         e.dbz = 1'b1;
      end else begin
`ifdef DIV_SIGNED_EN
         a = longint'($signed(qv));
         b = longint'($signed(mv));
`else
         a = longint'({32'd0, qv});
         b = longint'({32'd0, mv});
`endif
         quo   = a / b;   // truncates toward zero, remainder follows dividend
         rem   = a % b;
         e.z   = {rem[31:0], quo[31:0]};
         e.dbz = 1'b0;
      end
      return e;
   endfunction

   // Monitor: compares every completion against the head of the scoreboard.
   initial begin
      exp_t e;
      bit   prev_done;
      prev_done = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         if (prev_done) begin
            chk("done_pulse", {63'd0, done}, 64'd0);
         end
         if (done) begin
            if (exp_q.size() == 0) begin
               total++;
               bad++;
               $display("FAIL unexpected_done: got done with z=0x%0h, required no done", z);
            end else begin
               e = exp_q.pop_front();
               $display("txn cycle=%0d z=0x%016h dbz=%0b exp_z=0x%016h exp_dbz=%0b",
                        cyc, z, div_by_zero, e.z, e.dbz);
               chk("result_z", z, e.z);
               chk("div_by_zero", {63'd0, div_by_zero}, {63'd0, e.dbz});
               chk("latency", 64'(cyc - e.acc), 64'd33);
            end
         end
         prev_done = done;
      end
   end

   // Driver. mode 0: plain, 1: extra start pulse at edge 10, 2: abort at edge 15.
   task automatic run_div(input logic [31:0] qv, input logic [31:0] mv, input int mode);
      exp_t e;
      int   acc;
      int   ed;
      bit   got;
      start = 1'b1;
      Q     = qv;
      M     = mv;
      @(posedge clk);
      #1;
      start = 1'b0;
      acc   = cyc;
      e     = model(qv, mv);
      e.acc = acc;
      exp_q.push_back(e);
      Q = $urandom;
      M = $urandom;
      chk("busy_rise", {63'd0, busy}, 64'd1);
      got = 1'b0;
      for (int k = 0; k < 45 && !got; k++) begin
         @(posedge clk);
         #1;
         ed = cyc - acc;
         if (mode == 1 && ed == 9) begin
            start = 1'b1;
            Q     = ~qv;
            M     = mv + 32'd3;
         end
         if (mode == 1 && ed == 10) begin
            start = 1'b0;
         end
         if (mode == 2 && ed == 15) begin
            clr = 1'b0;
            #1;
            chk("abort_z", z, 64'd0);
            chk("abort_busy", {63'd0, busy}, 64'd0);
            chk("abort_done", {63'd0, done}, 64'd0);
            chk("abort_dbz", {63'd0, div_by_zero}, 64'd0);
            void'(exp_q.pop_back());
            $display("txn aborted at edge 15 q=0x%08h m=0x%08h", qv, mv);
            #1;
            clr = 1'b1;
            return;
         end
         if (ed == 32) begin
            chk("busy_edge32", {63'd0, busy}, 64'd1);
            chk("done_edge32", {63'd0, done}, 64'd0);
         end
         if (ed == 33) begin
            chk("busy_edge33", {63'd0, busy}, 64'd0);
            chk("done_edge33", {63'd0, done}, 64'd1);
            got = 1'b1;
         end
      end
      if (!got) begin
         total++;
         bad++;
         $display("FAIL timeout: no completion edge seen, required edge 33");
      end
      @(posedge clk);
      #1;   // edge 34: next accept can be requested for edge 35
   endtask

   initial begin
      logic [31:0] qv;
      logic [31:0] mv;
      int          sel;
      total = 0;
      bad   = 0;
      clr   = 1'b0;
      start = 1'b0;
      Q     = 32'd0;
      M     = 32'd0;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_z", z, 64'd0);
      chk("reset_busy", {63'd0, busy}, 64'd0);
      chk("reset_done", {63'd0, done}, 64'd0);
      chk("reset_dbz", {63'd0, div_by_zero}, 64'd0);
      clr = 1'b1;
      @(posedge clk);
      #1;

      // Directed cases.
      run_div(32'd1, 32'd2, 0);
      run_div(32'd2, 32'd4, 0);
      run_div(32'd100, 32'd7, 0);
      run_div(32'hFFFF_FFF9, 32'd2, 0);
      run_div(32'h1234_5678, 32'd0, 0);
      run_div(32'd50, 32'd5, 0);
      run_div(32'h8000_0000, 32'hFFFF_FFFF, 0);
      run_div(32'd1000, 32'd33, 1);
      run_div(32'hDEAD_BEEF, 32'd17, 2);
      run_div(32'd77, 32'd8, 0);

      // Randomized cases with biased operand classes.
      for (int n = 0; n < 40; n++) begin
         sel = $urandom_range(0, 6);
         qv  = $urandom;
         mv  = $urandom;
         case (sel)
            0: mv = 32'd0;
            1: mv = 32'hFFFF_FFFF;
            2: mv = 32'($urandom_range(1, 15));
            3: begin qv = 32'h8000_0000; mv = 32'hFFFF_FFFF; end
            4: mv = mv >> $urandom_range(0, 31);
            default: ;
         endcase
         run_div(qv, mv, (n % 10 == 7) ? 1 : ((n % 13 == 5) ? 2 : 0));
      end

      repeat (5) @(posedge clk);
      #1;
      chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
